// File: rtl/serial_adder_16bit.sv
// rtl/serial_adder_16bit.sv - nibble-serial 16-bit add/subtract unit with flag outputs
// One 4-bit adder is reused over four cycles, LSB nibble first, with the carry held in r_c.

module full_adder_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [4:0] w_total;

  assign w_total = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
  assign o_sum   = w_total[3:0];
  assign o_cout  = w_total[4];
endmodule

module serial_adder_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sub,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] Sum,
  output logic        Cout,
  output logic        Ovfl,
  output logic        Zero
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_opa;
  logic [15:0] r_opb;
  logic [11:0] r_partial;
  logic [1:0]  r_cnt;
  logic        r_c;
  logic        r_sign_a;
  logic        r_sign_b;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_sum;
  logic        r_cout;
  logic        r_ovfl;
  logic        r_zero;

  logic [3:0]  w_nib_sum;
  logic        w_nib_cout;
  logic [15:0] w_partial_next;
  logic [15:0] w_opb_in;

  full_adder_4bit u_adder (
    .i_a    (r_opa[3:0]),
    .i_b    (r_opb[3:0]),
    .i_cin  (r_c),
    .o_sum  (w_nib_sum),
    .o_cout (w_nib_cout)
  );

  // Only the top 12 bits of the shift register are kept; the low nibble falls off each shift.
  assign w_partial_next = {w_nib_sum, r_partial};
  assign w_opb_in       = sub ? ~B : B;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_opa     <= 16'h0000;
      r_opb     <= 16'h0000;
      r_partial <= 12'h000;
      r_cnt     <= 2'd0;
      r_c       <= 1'b0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sum     <= 16'h0000;
      r_cout    <= 1'b0;
      r_ovfl    <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_opa    <= A;
            r_opb    <= w_opb_in;
            r_c      <= sub;
            r_cnt    <= 2'd0;
            r_sign_a <= A[15];
            r_sign_b <= w_opb_in[15];
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_partial <= w_partial_next[15:4];
          r_opa     <= {4'h0, r_opa[15:4]};
          r_opb     <= {4'h0, r_opb[15:4]};
          r_c       <= w_nib_cout;
          r_cnt     <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_sum   <= w_partial_next;
            r_cout  <= w_nib_cout;
            r_ovfl  <= (r_sign_a == r_sign_b) && (w_partial_next[15] != r_sign_a);
            r_zero  <= (w_partial_next == 16'h0000);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Sum  = r_sum;
  assign Cout = r_cout;
  assign Ovfl = r_ovfl;
  assign Zero = r_zero;
endmodule

// File: tb/tb_serial_adder_16bit.sv
// tb/tb_serial_adder_16bit.sv - directed self-checking bench for serial_adder_16bit

module tb_serial_adder_16bit;
  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] Sum;
  logic        Cout;
  logic        Ovfl;
  logic        Zero;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;

  serial_adder_16bit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout),
    .Ovfl  (Ovfl),
    .Zero  (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (done === 1'b1) n_done++;
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] e_sum, input logic e_cout,
                        input logic e_ovfl, input logic e_zero);
    A = a; B = b; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("%s busy c%0d", tag, i), {31'd0, busy}, 32'd1);
      check($sformatf("%s done c%0d", tag, i), {31'd0, done}, 32'd0);
      if (i < 4) tick();
    end
    tick();
    check({tag, " done c5"}, {31'd0, done}, 32'd1);
    check({tag, " busy c5"}, {31'd0, busy}, 32'd0);
    check({tag, " Sum"},  {16'd0, Sum},    {16'd0, e_sum});
    check({tag, " Cout"}, {31'd0, Cout},   {31'd0, e_cout});
    check({tag, " Ovfl"}, {31'd0, Ovfl},   {31'd0, e_ovfl});
    check({tag, " Zero"}, {31'd0, Zero},   {31'd0, e_zero});
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; sub = 1'b0; A = 16'hFFFF; B = 16'hFFFF;
    tick();
    tick();
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst Sum",  {16'd0, Sum},  32'd0);
    check("rst flags", {29'd0, Cout, Ovfl, Zero}, 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();

    run_op("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    tick();
    run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    tick();
    run_op("t3", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    tick();
    run_op("t4a", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("t4b", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    tick();

    // Start ignored during RUN and operand changes after acceptance.
    n_done = 0;
    A = 16'h0001; B = 16'h0001; sub = 1'b0; start = 1'b1;
    tick();
    A = 16'hFFFF; B = 16'hFFFF; start = 1'b1;
    tick();
    A = 16'h1234; B = 16'h5678; sub = 1'b1;
    tick();
    A = 16'hFFFF; B = 16'h0000;
    tick();
    start = 1'b0;
    tick();
    check("t5 done c5", {31'd0, done}, 32'd1);
    check("t5 Sum", {16'd0, Sum}, 32'h0002);
    for (int i = 0; i < 5; i++) tick();
    check("t5 done count", n_done, 32'd1);

    // Reset mid-RUN aborts the operation.
    A = 16'h1111; B = 16'h2222; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6 busy", {31'd0, busy}, 32'd0);
    check("t6 done", {31'd0, done}, 32'd0);
    check("t6 Sum",  {16'd0, Sum},  32'd0);
    check("t6 flags", {29'd0, Cout, Ovfl, Zero}, 32'd0);
    n_done = 0;
    for (int i = 0; i < 10; i++) tick();
    check("t6 no done", n_done, 32'd0);
    check("t6 idle busy", {31'd0, busy}, 32'd0);
    run_op("t6r", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
